// File: rtl/regfile_ctrl_pkg.sv
// rtl/regfile_ctrl_pkg.sv - shared constants and FSM state type for the register-file write controller
package regfile_ctrl_pkg;

  localparam int XLEN_C   = 32;
  localparam int REG_AW_C = 5;
  localparam int NREGS_C  = 32;

  typedef enum logic {INIT, RUN} wbc_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, search starts at ptr and wraps modulo N
module rr_arbiter #(
  parameter int N = 2,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_idx
);

  int   idx;
  logic found;

  // first requester at or above ptr (wrapping) wins; at most one grant bit
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        found        = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = W'(idx);
      end
    end
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// rtl/regfile_wb_ctrl.sv - register-file write-port controller: clear sweep, RR writeback, RAW scoreboard (option REGFILE_BYPASS_EN)
module regfile_wb_ctrl
  import regfile_ctrl_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int XLEN   = XLEN_C,
  parameter int REG_AW = REG_AW_C
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*REG_AW-1:0] req_addr,
  input  logic [N_REQ*XLEN-1:0]   req_data,
  output logic [N_REQ-1:0]        req_ready,
  input  logic                    iss_valid,
  input  logic [REG_AW-1:0]       iss_rd,
  input  logic [REG_AW-1:0]       chk_rs1,
  input  logic [REG_AW-1:0]       chk_rs2,
  output logic                    busy_rs1,
  output logic                    busy_rs2,
  output logic [REG_AW-1:0]       rf_a3,
  output logic [XLEN-1:0]         rf_wd3,
  output logic                    rf_we3,
  output logic                    init_done
`ifdef REGFILE_BYPASS_EN
  ,
  output logic                    fwd_rs1_valid,
  output logic                    fwd_rs2_valid,
  output logic [XLEN-1:0]         fwd_rs1_data,
  output logic [XLEN-1:0]         fwd_rs2_data
`endif
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int NREGS = (REG_AW == REG_AW_C) ? NREGS_C : (1 << REG_AW);

  wbc_state_t        state, state_nx;
  logic [REG_AW-1:0] cnt;
  logic [IDX_W-1:0]  rr_ptr, gnt_idx;
  logic [N_REQ-1:0]  gnt;
  logic [NREGS-1:0]  sb, sb_nx;
  logic              accept;
  logic [REG_AW-1:0] acc_addr;
  logic [XLEN-1:0]   acc_data;
  logic              hit1, hit2;

  rr_arbiter #(.N(N_REQ), .W(IDX_W)) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign acc_addr = req_addr[int'(gnt_idx)*REG_AW +: REG_AW];
  assign acc_data = req_data[int'(gnt_idx)*XLEN +: XLEN];

  // state register; RUN is left only through reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= INIT;
    else      state <= state_nx;
  end

  // next state plus the grant/accept qualification that only applies in RUN
  always_comb begin
    state_nx  = state;
    req_ready = '0;
    init_done = 1'b0;
    accept    = 1'b0;
    case (state)
      INIT: if (cnt == '1) state_nx = RUN;
      RUN: begin
        init_done = 1'b1;
        req_ready = gnt;
        accept    = |gnt;
      end
      default: state_nx = INIT;
    endcase
  end

  // write-port register: zero sweep in INIT, accepted writeback in RUN; x0 writes drop WE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= REG_AW'(1);
      rr_ptr <= '0;
      rf_a3  <= '0;
      rf_wd3 <= '0;
      rf_we3 <= 1'b0;
    end else if (state == INIT) begin
      rf_a3  <= cnt;
      rf_wd3 <= '0;
      rf_we3 <= 1'b1;
      cnt    <= cnt + REG_AW'(1);
    end else if (accept) begin
      rf_a3  <= acc_addr;
      rf_wd3 <= acc_data;
      rf_we3 <= (acc_addr != '0);
      rr_ptr <= (gnt_idx == IDX_W'(N_REQ-1)) ? '0 : gnt_idx + IDX_W'(1);
    end else begin
      rf_we3 <= 1'b0;
    end
  end

  // scoreboard update: clear on writeback, set on issue; the set is applied last so the newer producer wins
  always_comb begin
    sb_nx = sb;
    if (accept) sb_nx[acc_addr] = 1'b0;
    if (state == RUN && iss_valid && iss_rd != '0) sb_nx[iss_rd] = 1'b1;
    sb_nx[0] = 1'b0;
  end

  // scoreboard register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sb <= '0;
    else      sb <= sb_nx;
  end

  // hazard lookup; the in-flight write either stalls decode or is forwarded to it
  always_comb begin
    hit1 = rf_we3 && (rf_a3 == chk_rs1) && (chk_rs1 != '0);
    hit2 = rf_we3 && (rf_a3 == chk_rs2) && (chk_rs2 != '0);
`ifdef REGFILE_BYPASS_EN
    busy_rs1      = sb[chk_rs1];
    busy_rs2      = sb[chk_rs2];
    fwd_rs1_valid = hit1;
    fwd_rs2_valid = hit2;
    fwd_rs1_data  = rf_wd3;
    fwd_rs2_data  = rf_wd3;
`else
    busy_rs1 = sb[chk_rs1] | hit1;
    busy_rs2 = sb[chk_rs2] | hit2;
`endif
    if (chk_rs1 == '0) busy_rs1 = 1'b0;
    if (chk_rs2 == '0) busy_rs2 = 1'b0;
    if (state == INIT) begin
      busy_rs1 = 1'b1;
      busy_rs2 = 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// tb/tb_regfile_wb_ctrl.sv - self-checking bench for regfile_wb_ctrl
module tb_regfile_wb_ctrl;

  localparam int N = 2;
`ifdef REGFILE_BYPASS_EN
  localparam int NB = 0;
`else
  localparam int NB = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [9:0]  req_addr;
  logic [63:0] req_data;
  logic [1:0]  req_ready;
  logic        iss_valid;
  logic [4:0]  iss_rd, chk_rs1, chk_rs2;
  logic        busy_rs1, busy_rs2;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd3;
  logic        rf_we3, init_done;
`ifdef REGFILE_BYPASS_EN
  logic        fwd_rs1_valid, fwd_rs2_valid;
  logic [31:0] fwd_rs1_data, fwd_rs2_data;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_wb_ctrl #(.N_REQ(2), .XLEN(32), .REG_AW(5)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .iss_valid(iss_valid), .iss_rd(iss_rd), .chk_rs1(chk_rs1),
    .chk_rs2(chk_rs2), .busy_rs1(busy_rs1), .busy_rs2(busy_rs2), .rf_a3(rf_a3),
    .rf_wd3(rf_wd3), .rf_we3(rf_we3), .init_done(init_done)
`ifdef REGFILE_BYPASS_EN
    , .fwd_rs1_valid(fwd_rs1_valid), .fwd_rs2_valid(fwd_rs2_valid),
    .fwd_rs1_data(fwd_rs1_data), .fwd_rs2_data(fwd_rs2_data)
`endif
  );

  typedef struct {
    logic [1:0]  v;
    logic [4:0]  a0, a1;
    logic [31:0] d0, d1;
    logic        iss;
    logic [4:0]  rd, rs1, rs2;
    logic [1:0]  e_rdy;
    logic        e_b1, e_b2, e_we;
    logic [4:0]  e_a3;
    logic [31:0] e_wd;
  } vec_t;

  vec_t tbl[18];

  // reference model state
  bit          m_sb[32];
  int          m_ptr;
  logic        m_we;
  logic [4:0]  m_a3;
  logic [31:0] m_wd;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  function automatic vec_t mk(input int v, input int a0, input int d0, input int a1, input int d1,
                              input int iss, input int rd, input int rs1, input int rs2,
                              input int rdy, input int b1, input int b2,
                              input int we, input int a3, input int wd);
    vec_t t;
    t.v = 2'(v);     t.a0 = 5'(a0);   t.d0 = 32'(d0);  t.a1 = 5'(a1);  t.d1 = 32'(d1);
    t.iss = 1'(iss); t.rd = 5'(rd);   t.rs1 = 5'(rs1); t.rs2 = 5'(rs2);
    t.e_rdy = 2'(rdy); t.e_b1 = 1'(b1); t.e_b2 = 1'(b2);
    t.e_we = 1'(we); t.e_a3 = 5'(a3); t.e_wd = 32'(wd);
    return t;
  endfunction

  task automatic drive(input vec_t t);
    req_valid = t.v;
    req_addr  = {t.a1, t.a0};
    req_data  = {t.d1, t.d0};
    iss_valid = t.iss;
    iss_rd    = t.rd;
    chk_rs1   = t.rs1;
    chk_rs2   = t.rs2;
  endtask

  // checks comb outputs against the model write stage, then advances the model by one accept/issue
  task automatic step_model(input string tag, input logic [1:0] v, input logic [4:0] a0, input logic [4:0] a1,
                            input logic [31:0] d0, input logic [31:0] d1, input logic iss, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic [4:0] rs2);
    int g;
    int idx;
    logic [1:0]  e_rdy;
    logic        eb1, eb2;
    logic [4:0]  addr;
    logic [31:0] data;
    g = -1;
    for (int k = 0; k < N; k++) begin
      idx = (m_ptr + k) % N;
      if (g < 0 && v[idx]) g = idx;
    end
    e_rdy = '0;
    if (g >= 0) e_rdy[g] = 1'b1;
    eb1 = (rs1 != 0) && (m_sb[rs1] || (NB == 1 && m_we && m_a3 == rs1));
    eb2 = (rs2 != 0) && (m_sb[rs2] || (NB == 1 && m_we && m_a3 == rs2));
    check({tag, "_ready"}, 64'(req_ready), 64'(e_rdy));
    check({tag, "_busy1"}, 64'(busy_rs1), 64'(eb1));
    check({tag, "_busy2"}, 64'(busy_rs2), 64'(eb2));
`ifdef REGFILE_BYPASS_EN
    check({tag, "_fwd1"}, 64'(fwd_rs1_valid), 64'(m_we && m_a3 == rs1 && rs1 != 0));
    check({tag, "_fwd2"}, 64'(fwd_rs2_valid), 64'(m_we && m_a3 == rs2 && rs2 != 0));
    if (m_we && m_a3 == rs2 && rs2 != 0) check({tag, "_fwd2_data"}, 64'(fwd_rs2_data), 64'(m_wd));
`endif
    if (g >= 0) begin
      addr = (g == 0) ? a0 : a1;
      data = (g == 0) ? d0 : d1;
      m_we = (addr != 0);
      m_a3 = addr;
      m_wd = data;
      m_sb[addr] = 1'b0;
      m_ptr = (g + 1) % N;
    end else begin
      m_we = 1'b0;
    end
    if (iss && rd != 0) m_sb[rd] = 1'b1;
  endtask

  initial begin
    logic [1:0]  rv;
    logic [4:0]  ra0, ra1, rrd, rs1v, rs2v;
    logic [31:0] rd0, rd1;
    logic        riss;
    bit          seen;

    // reset state, with requests and an issue already asserted that INIT must ignore
    rst = 1'b0;
    req_valid = 2'b11; req_addr = {5'd2, 5'd1}; req_data = {32'd7, 32'd6};
    iss_valid = 1'b1; iss_rd = 5'd9; chk_rs1 = 5'd9; chk_rs2 = 5'd0;
    #3;
    check("rst_we3", 64'(rf_we3), 64'(0));
    check("rst_a3", 64'(rf_a3), 64'(0));
    check("rst_wd3", 64'(rf_wd3), 64'(0));
    check("rst_init_done", 64'(init_done), 64'(0));
    check("rst_ready", 64'(req_ready), 64'(0));
    check("rst_busy1", 64'(busy_rs1), 64'(1));

    // clear sweep: 31 writes of zero to x1..x31
    @(negedge clk) rst = 1'b1;
    for (int c = 1; c <= 31; c++) begin
      @(posedge clk); #1;
      check($sformatf("init%0d_we3", c), 64'(rf_we3), 64'(1));
      check($sformatf("init%0d_a3", c), 64'(rf_a3), 64'(c));
      check($sformatf("init%0d_wd3", c), 64'(rf_wd3), 64'(0));
      check($sformatf("init%0d_done", c), 64'(init_done), 64'(c == 31));
      if (c < 31) begin
        check($sformatf("init%0d_ready", c), 64'(req_ready), 64'(0));
        check($sformatf("init%0d_busy1", c), 64'(busy_rs1), 64'(1));
      end else begin
        req_valid = 2'b00;
        iss_valid = 1'b0;
      end
    end
    @(posedge clk); #1;
    check("post_init_we3", 64'(rf_we3), 64'(0));
    check("post_init_done", 64'(init_done), 64'(1));
    check("post_init_iss_ignored", 64'(busy_rs1), 64'(0));

    // directed vectors: alternation, single request, RAW scoreboard, x0 drop, in-flight write
    tbl[0]  = mk(3, 1, 100, 2, 200, 0, 0, 1, 2,  1, 0, 0,   1, 1, 100);
    tbl[1]  = mk(3, 1, 100, 2, 200, 0, 0, 1, 2,  2, NB, 0,  1, 2, 200);
    tbl[2]  = mk(3, 1, 100, 2, 200, 0, 0, 1, 2,  1, 0, NB,  1, 1, 100);
    tbl[3]  = mk(3, 1, 100, 2, 200, 0, 0, 1, 2,  2, NB, 0,  1, 2, 200);
    tbl[4]  = mk(1, 5, 10, 0, 0,    0, 0, 5, 2,  1, 0, NB,  1, 5, 10);
    tbl[5]  = mk(0, 0, 0, 0, 0,     0, 0, 5, 0,  0, NB, 0,  0, 5, 10);
    tbl[6]  = mk(0, 0, 0, 0, 0,     1, 7, 7, 0,  0, 0, 0,   0, 5, 10);
    tbl[7]  = mk(0, 0, 0, 0, 0,     0, 0, 7, 0,  0, 1, 0,   0, 5, 10);
    tbl[8]  = mk(2, 0, 0, 7, 77,    1, 7, 7, 0,  2, 1, 0,   1, 7, 77);
    tbl[9]  = mk(0, 0, 0, 0, 0,     0, 0, 7, 0,  0, 1, 0,   0, 7, 77);
    tbl[10] = mk(0, 0, 0, 0, 0,     0, 0, 7, 0,  0, 1, 0,   0, 7, 77);
    tbl[11] = mk(1, 7, 70, 0, 0,    0, 0, 7, 0,  1, 1, 0,   1, 7, 70);
    tbl[12] = mk(0, 0, 0, 0, 0,     0, 0, 7, 0,  0, NB, 0,  0, 7, 70);
    tbl[13] = mk(0, 0, 0, 0, 0,     0, 0, 7, 0,  0, 0, 0,   0, 7, 70);
    tbl[14] = mk(2, 0, 0, 0, 65535, 1, 0, 0, 0,  2, 0, 0,   0, 0, 65535);
    tbl[15] = mk(0, 0, 0, 0, 0,     0, 0, 0, 0,  0, 0, 0,   0, 0, 65535);
    tbl[16] = mk(1, 3, 40, 0, 0,    0, 0, 0, 0,  1, 0, 0,   1, 3, 40);
    tbl[17] = mk(0, 0, 0, 0, 0,     0, 0, 0, 3,  0, 0, NB,  0, 3, 40);

    m_we = 1'b0; m_a3 = 5'd31; m_wd = 32'd0;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      check($sformatf("tbl%0d_ready", i), 64'(req_ready), 64'(tbl[i].e_rdy));
      check($sformatf("tbl%0d_busy1", i), 64'(busy_rs1), 64'(tbl[i].e_b1));
      check($sformatf("tbl%0d_busy2", i), 64'(busy_rs2), 64'(tbl[i].e_b2));
`ifdef REGFILE_BYPASS_EN
      check($sformatf("tbl%0d_fwd2", i), 64'(fwd_rs2_valid),
            64'(m_we && m_a3 == tbl[i].rs2 && tbl[i].rs2 != 0));
      if (m_we && m_a3 == tbl[i].rs2 && tbl[i].rs2 != 0)
        check($sformatf("tbl%0d_fwd2_data", i), 64'(fwd_rs2_data), 64'(m_wd));
`endif
      @(posedge clk); #1;
      check($sformatf("tbl%0d_we3", i), 64'(rf_we3), 64'(tbl[i].e_we));
      check($sformatf("tbl%0d_a3", i), 64'(rf_a3), 64'(tbl[i].e_a3));
      check($sformatf("tbl%0d_wd3", i), 64'(rf_wd3), 64'(tbl[i].e_wd));
      m_we = tbl[i].e_we; m_a3 = tbl[i].e_a3; m_wd = tbl[i].e_wd;
    end

    // random traffic against the reference model; pointer and scoreboard follow from the table
    m_ptr = 1;
    for (int r = 0; r < 32; r++) m_sb[r] = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      rv   = 2'($urandom_range(0, 3));
      ra0  = 5'($urandom_range(0, 7));
      ra1  = 5'($urandom_range(0, 7));
      rd0  = $urandom;
      rd1  = $urandom;
      riss = 1'($urandom_range(0, 1));
      rrd  = 5'($urandom_range(0, 7));
      rs1v = 5'($urandom_range(0, 7));
      rs2v = 5'($urandom_range(0, 7));
      req_valid = rv; req_addr = {ra1, ra0}; req_data = {rd1, rd0};
      iss_valid = riss; iss_rd = rrd; chk_rs1 = rs1v; chk_rs2 = rs2v;
      #1;
      step_model($sformatf("rnd%0d", n), rv, ra0, ra1, rd0, rd1, riss, rrd, rs1v, rs2v);
      @(posedge clk); #1;
      check($sformatf("rnd%0d_we3", n), 64'(rf_we3), 64'(m_we));
      check($sformatf("rnd%0d_a3", n), 64'(rf_a3), 64'(m_a3));
      check($sformatf("rnd%0d_wd3", n), 64'(rf_wd3), 64'(m_wd));
    end

    // reset during RUN with a scoreboard bit set and a write in flight
    @(negedge clk);
    req_valid = 2'b11; req_addr = {5'd12, 5'd12}; req_data = {32'd5, 32'd5};
    iss_valid = 1'b1; iss_rd = 5'd12; chk_rs1 = 5'd12; chk_rs2 = 5'd0;
    @(posedge clk); #1;
    check("mid_we3", 64'(rf_we3), 64'(1));
    check("mid_a3", 64'(rf_a3), 64'(12));
    check("mid_busy1", 64'(busy_rs1), 64'(1));
    #2 rst = 1'b0;
    #1;
    check("arst_we3", 64'(rf_we3), 64'(0));
    check("arst_a3", 64'(rf_a3), 64'(0));
    check("arst_wd3", 64'(rf_wd3), 64'(0));
    check("arst_init_done", 64'(init_done), 64'(0));
    check("arst_ready", 64'(req_ready), 64'(0));
    check("arst_busy1", 64'(busy_rs1), 64'(1));
    @(negedge clk);
    rst = 1'b1; req_valid = 2'b00; iss_valid = 1'b0;
    @(posedge clk); #1;
    check("restart_we3", 64'(rf_we3), 64'(1));
    check("restart_a3", 64'(rf_a3), 64'(1));
    check("restart_wd3", 64'(rf_wd3), 64'(0));
    seen = 1'b0;
    for (int w = 0; w < 40 && !seen; w++) begin
      @(posedge clk); #1;
      if (init_done) seen = 1'b1;
    end
    check("restart_init_done_in_time", 64'(seen), 64'(1));
    @(posedge clk); #1;
    check("restart_sb_cleared", 64'(busy_rs1), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
